// File: rtl/romix_scratchpad_ctrl.sv
// Scratchpad sequencer for scrypt ROMix: stores N X blocks at V[i], then for
// each returned X fetches V[Integerify(X) mod N] and hands it back to the core.
module romix_scratchpad_ctrl #(
    parameter int ADDR_BITS   = 17,
    parameter int DATA_BITS   = 1024,
    parameter int BLOCK_SHIFT = 7,
    parameter int N_BLOCKS    = 1024,
    parameter int IDX_BITS    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 x_valid,
    input  logic [DATA_BITS-1:0] x_data,
    output logic                 x_ready,
    output logic                 v_valid,
    output logic [DATA_BITS-1:0] v_data,
    input  logic                 v_ready,
    output logic                 mem_r_enable,
    output logic                 mem_w_enable,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_w_data,
    input  logic [DATA_BITS-1:0] mem_r_data
);

    localparam int CNT_W = IDX_BITS + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BLOCKS - 1);
    // Integerify: first little-endian word of the last 64-byte sub-block.
    localparam int J_LSB = DATA_BITS / 2;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RD_WAIT,
        V_OUT,
        FINISH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             x_hs;
    logic             v_hs;
    logic [IDX_BITS-1:0] j_idx;

    assign x_hs  = x_valid & x_ready;
    assign v_hs  = v_valid & v_ready;
    assign j_idx = x_data[J_LSB +: IDX_BITS];

    function automatic logic [ADDR_BITS-1:0] block_addr(input logic [IDX_BITS-1:0] idx);
        return ADDR_BITS'(idx) << BLOCK_SHIFT;
    endfunction

    // NOTE: all state and outputs are updated with non-blocking assignments so
    // every branch sees the pre-edge values of cnt/state regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            x_ready      <= 1'b0;
            v_valid      <= 1'b0;
            mem_r_enable <= 1'b0;
            mem_w_enable <= 1'b0;
            mem_addr     <= '0;
            // NOTE: the wide data registers are cleared too so nothing from an
            // aborted run is visible; the scratchpad contents are left alone.
            mem_w_data   <= '0;
            v_data       <= '0;
        end else begin
            mem_w_enable <= 1'b0;
            mem_r_enable <= 1'b0;
            done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= WRITE;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        x_ready <= 1'b1;
                    end
                end

                WRITE: begin
                    if (x_hs) begin
                        mem_w_enable <= 1'b1;
                        mem_addr     <= block_addr(cnt[IDX_BITS-1:0]);
                        mem_w_data   <= x_data;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= READ;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                READ: begin
                    if (x_hs) begin
                        mem_r_enable <= 1'b1;
                        mem_addr     <= block_addr(j_idx);
                        x_ready      <= 1'b0;
                        state        <= RD_WAIT;
                    end
                end

                // Scratchpad read data is valid while mem_r_enable is high.
                RD_WAIT: begin
                    v_data  <= mem_r_data;
                    v_valid <= 1'b1;
                    state   <= V_OUT;
                end

                V_OUT: begin
                    if (v_hs) begin
                        v_valid <= 1'b0;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            x_ready <= 1'b1;
                            state   <= READ;
                        end
                    end
                end

                FINISH: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_romix_scratchpad_ctrl.sv
// Directed bench for romix_scratchpad_ctrl with N_BLOCKS=4 and a behavioural
// scratchpad (synchronous write, combinational read while r_enable is high).
module tb_romix_scratchpad_ctrl;

    localparam int ADDR_BITS   = 17;
    localparam int DATA_BITS   = 1024;
    localparam int BLOCK_SHIFT = 7;
    localparam int N_BLOCKS    = 4;
    localparam int IDX_BITS    = 2;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 x_valid;
    logic [DATA_BITS-1:0] x_data;
    logic                 x_ready;
    logic                 v_valid;
    logic [DATA_BITS-1:0] v_data;
    logic                 v_ready;
    logic                 mem_r_enable;
    logic                 mem_w_enable;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_w_data;
    logic [DATA_BITS-1:0] mem_r_data;

    int n_tests = 0;
    int n_fail  = 0;

    romix_scratchpad_ctrl #(
        .ADDR_BITS  (ADDR_BITS),
        .DATA_BITS  (DATA_BITS),
        .BLOCK_SHIFT(BLOCK_SHIFT),
        .N_BLOCKS   (N_BLOCKS),
        .IDX_BITS   (IDX_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .x_valid     (x_valid),
        .x_data      (x_data),
        .x_ready     (x_ready),
        .v_valid     (v_valid),
        .v_data      (v_data),
        .v_ready     (v_ready),
        .mem_r_enable(mem_r_enable),
        .mem_w_enable(mem_w_enable),
        .mem_addr    (mem_addr),
        .mem_w_data  (mem_w_data),
        .mem_r_data  (mem_r_data)
    );

    // Scratchpad model: 1024 blocks of 128 bytes.
    logic [DATA_BITS-1:0] spm [0:1023];
    logic [9:0]           spm_idx;
    assign spm_idx    = 10'(mem_addr >> BLOCK_SHIFT);
    assign mem_r_data = mem_r_enable ? spm[spm_idx] : '0;
    always @(posedge clk) begin
        if (mem_w_enable) spm[spm_idx] <= mem_w_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 128 bits shown)", tag, got[127:0], exp[127:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1023:0] blk(input logic [7:0] b);
        logic [1023:0] v;
        v      = '0;
        v[7:0] = b;
        return v;
    endfunction

    // X for the read phase: index bits at [513:512], unrelated bits set around them.
    function automatic logic [1023:0] rd_x(input int j);
        logic [1023:0] v;
        v            = '0;
        v[31:0]      = 32'hDEADBEEF;
        v[512 +: 2]  = 2'(j);
        v[514 +: 8]  = 8'hFF;
        v[1023 -: 8] = 8'h5A;
        return v;
    endfunction

    task automatic write_phase(input logic [7:0] base);
        for (int i = 0; i < N_BLOCKS; i++) begin
            x_valid = 1'b1;
            x_data  = blk(base + 8'(i));
            tick();
            check($sformatf("wr%0d_wen", i), mem_w_enable, 1);
            check($sformatf("wr%0d_addr", i), mem_addr, 128 * i);
            check($sformatf("wr%0d_data", i), mem_w_data, blk(base + 8'(i)));
            check($sformatf("wr%0d_ren", i), mem_r_enable, 0);
        end
        x_valid = 1'b0;
    endtask

    task automatic read_iter(input int j, input logic [7:0] exp_b, input int hold, input bit last);
        check($sformatf("rd%0d_xrdy_pre", j), x_ready, 1);
        x_valid = 1'b1;
        x_data  = rd_x(j);
        tick();
        check($sformatf("rd%0d_ren", j), mem_r_enable, 1);
        check($sformatf("rd%0d_addr", j), mem_addr, 128 * j);
        check($sformatf("rd%0d_wen", j), mem_w_enable, 0);
        check($sformatf("rd%0d_xrdy_wait", j), x_ready, 0);
        check($sformatf("rd%0d_vval_early", j), v_valid, 0);
        x_data = rd_x((j + 1) % N_BLOCKS);
        tick();
        check($sformatf("rd%0d_vval", j), v_valid, 1);
        check($sformatf("rd%0d_vdata", j), v_data, blk(exp_b));
        check($sformatf("rd%0d_ren_off", j), mem_r_enable, 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check($sformatf("bp%0d_vval", h), v_valid, 1);
            check($sformatf("bp%0d_vdata", h), v_data, blk(exp_b));
            check($sformatf("bp%0d_xrdy", h), x_ready, 0);
            check($sformatf("bp%0d_ren", h), mem_r_enable, 0);
            check($sformatf("bp%0d_wen", h), mem_w_enable, 0);
        end
        x_valid = 1'b0;
        v_ready = 1'b1;
        tick();
        v_ready = 1'b0;
        check($sformatf("rd%0d_vval_drop", j), v_valid, 0);
        check($sformatf("rd%0d_xrdy_post", j), x_ready, last ? 0 : 1);
        check($sformatf("rd%0d_done", j), done, last ? 1 : 0);
        check($sformatf("rd%0d_busy", j), busy, last ? 0 : 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b1;
        x_valid = 1'b1;
        x_data  = blk(8'h77);
        v_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_xrdy", x_ready, 0);
        check("rst_vval", v_valid, 0);
        check("rst_ren", mem_r_enable, 0);
        check("rst_wen", mem_w_enable, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_w_data, 0);
        check("rst_vdata", v_data, 0);

        // Run 1: write, read with backpressure, complete.
        rst     = 1'b0;
        x_valid = 1'b0;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_xrdy", x_ready, 1);
        write_phase(8'hA0);
        read_iter(2, 8'hA2, 5, 1'b0);
        read_iter(3, 8'hA3, 0, 1'b0);
        read_iter(0, 8'hA0, 0, 1'b0);
        read_iter(1, 8'hA1, 0, 1'b1);
        tick();
        check("fin1_done", done, 0);
        check("fin1_busy", busy, 0);
        check("fin1_xrdy", x_ready, 0);

        // Run 2: start held high throughout must be ignored.
        start = 1'b1;
        tick();
        check("run2_busy", busy, 1);
        write_phase(8'hA0);
        read_iter(3, 8'hA3, 0, 1'b0);
        read_iter(0, 8'hA0, 0, 1'b0);
        read_iter(1, 8'hA1, 0, 1'b0);
        read_iter(3, 8'hA3, 0, 1'b1);
        start = 1'b0;
        tick();
        check("fin2_done", done, 0);
        check("fin2_busy", busy, 0);

        // Run 3: abort with reset while a read is in flight.
        start = 1'b1;
        tick();
        start = 1'b0;
        write_phase(8'hA0);
        read_iter(0, 8'hA0, 0, 1'b0);
        x_valid = 1'b1;
        x_data  = rd_x(1);
        tick();
        check("abort_ren", mem_r_enable, 1);
        rst     = 1'b1;
        x_valid = 1'b0;
        tick();
        check("abort_vval0", v_valid, 0);
        check("abort_ren0", mem_r_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_vdata", v_data, 0);
        tick();
        check("abort_vval1", v_valid, 0);
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_vval", v_valid, 0);
        x_valid = 1'b1;
        x_data  = blk(8'hC0);
        tick();
        x_valid = 1'b0;
        check("restart_wen", mem_w_enable, 1);
        check("restart_addr", mem_addr, 0);
        check("restart_wdata", mem_w_data, blk(8'hC0));
        tick();
        check("restart_wen_off", mem_w_enable, 0);
        check("restart_vval_off", v_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/romix_scratchpad_ctrl.md
Name: romix_scratchpad_ctrl

Overview:
Sequences the 128 KB scratchpad SRAM through the two scrypt ROMix phases.
- Write phase: stores N successive 1024-bit X blocks from the BlockMix core at V[i].
- Read phase: for each X returned by the core, computes j = Integerify(X) mod N, fetches V[j] and hands it back to the core.
- Sits between the BlockMix core and the scratchpad. It is the sole driver of the scratchpad's r_enable/w_enable/addr/w_data.

Parameters:
- ADDR_BITS, 17, scratchpad byte-address width.
- DATA_BITS, 1024, block width (128 bytes).
- BLOCK_SHIFT, 7, log2 of block size in bytes; block i sits at byte address i << BLOCK_SHIFT.
- N_BLOCKS, 1024, scrypt N; power of two; at most 2^(ADDR_BITS-BLOCK_SHIFT).
- IDX_BITS, 10, log2(N_BLOCKS).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: begin a ROMix run; sampled only in IDLE.
- busy, out, 1: high from the cycle after start is accepted until done.
- done, out, 1: one-cycle pulse when the run completes.
- x_valid, in, 1: core presents an X block.
- x_data, in, DATA_BITS: X block; byte 0 at bits [7:0].
- x_ready, out, 1: controller accepts X; transfer occurs when x_valid & x_ready.
- v_valid, out, 1: V[j] available to core.
- v_data, out, DATA_BITS: V[j] contents.
- v_ready, in, 1: core accepts V; transfer occurs when v_valid & v_ready.
- mem_r_enable, out, 1: scratchpad read enable.
- mem_w_enable, out, 1: scratchpad write enable.
- mem_addr, out, ADDR_BITS: scratchpad byte address.
- mem_w_data, out, DATA_BITS: scratchpad write data.
- mem_r_data, in, DATA_BITS: scratchpad read data; valid in the cycle r_enable is high.

Behaviour:
- Reset values:
  - state = IDLE and cnt = 0.
  - busy, done, x_ready, v_valid, mem_r_enable and mem_w_enable are all 0.
  - mem_addr, mem_w_data and v_data are all 0.
- Reset mid-run aborts immediately with no further memory access; a partially written V is not cleared.
- All mem_* outputs are registered. mem_r_enable and mem_w_enable are never high in the same cycle.
- State IDLE:
  - x_ready = 0.
  - start = 1 moves to WRITE with cnt = 0.
  - start in any other state is ignored.
- State WRITE:
  - x_ready = 1.
  - On an X handshake in cycle T, at cycle T+1: mem_w_enable = 1, mem_addr = cnt << BLOCK_SHIFT, mem_w_data = x_data.
  - mem_w_enable drops at T+2 unless another handshake occurred at T+1. Back-to-back writes run at 1 per cycle.
  - cnt increments on each handshake.
  - The handshake with cnt == N_BLOCKS-1 moves to READ with cnt = 0; the final write still issues at T+1.
- State READ:
  - x_ready = 1.
  - On an X handshake at T: j = x_data[512 +: IDX_BITS]. This is the low bits of the first little-endian 32-bit word of the last 64-byte sub-block.
  - At T+1: mem_r_enable = 1 and mem_addr = j << BLOCK_SHIFT. The state moves to RD_WAIT.
- State RD_WAIT:
  - x_ready = 0.
  - At the end of T+1, v_data is captured from mem_r_data.
  - At T+2: mem_r_enable = 0, v_valid = 1, and the state moves to V_OUT.
- State V_OUT:
  - x_ready = 0.
  - v_valid and v_data are held stable until v_ready.
  - On the V handshake, v_valid drops the next cycle and cnt increments.
  - If cnt was N_BLOCKS-1, go to FINISH; otherwise return to READ.
- State FINISH:
  - done = 1 for exactly one cycle.
  - busy = 0 in the same cycle.
  - Next state is IDLE.
- Counter:
  - cnt is IDX_BITS+1 bits wide.
  - Comparisons are against N_BLOCKS-1, and cnt wraps to 0 on each phase change.
- An X handshake is impossible while x_ready = 0; x_valid held high is simply stalled.
- The latency from X accept to v_valid is exactly 2 cycles.

Test Plan (bench overrides N_BLOCKS=4, IDX_BITS=2; scratchpad model attached):
1. Reset check: assert rst for 3 cycles with x_valid = 1 and start = 1 → all outputs are 0 and x_ready = 0. After rst falls, start = 1 → busy = 1 on the next cycle.
2. Write phase:
   - Stimulus: feed X = 0xA0, 0xA1, 0xA2, 0xA3 (zero-extended) on consecutive cycles.
   - Response: mem_w_enable is high for 4 consecutive cycles with mem_addr = 0, 128, 256, 384 and mem_w_data matching the feed; mem_r_enable stays 0 throughout.
3. Read path:
   - Stimulus: X with bits [513:512] = 2'b10.
   - Response: 1 cycle later mem_r_enable = 1 and mem_addr = 256, with mem_w_enable = 0. 2 cycles after accept, v_valid = 1 and v_data = 0xA2.
4. Backpressure: hold v_ready = 0 for 5 cycles → v_valid and v_data are stable, x_ready = 0, and no memory enable is asserted. Raise v_ready → handshake occurs and x_ready = 1 on the next cycle.
5. Completion: 4 read iterations with j = 3, 0, 1, 3 → v_data = 0xA3, 0xA0, 0xA1, 0xA3. After the 4th V handshake, done pulses for one cycle, busy falls and x_ready = 0. start during the run has no effect.
6. Abort:
   - Stimulus: assert rst in RD_WAIT, then release it and issue start.
   - Response: v_valid never rises for the aborted read, and the new run's writes begin at mem_addr = 0.
